// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply or
// restoring divide, one sign-fix cycle, then a one-cycle done pulse.
module md_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] read_data_1,
  input  logic [31:0] read_data_2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [W-1:0]    opnd;     // multiplicand (mul) or divisor (div)
  logic [W-1:0]    sh;       // multiplier (shifts right) or dividend (shifts left)
  logic [2*W-1:0]  acc;      // product, or {remainder, quotient}
  logic [CW-1:0]   cnt;
  logic            neg_q;
  logic            neg_r;
  logic            div0;

  logic            a_signed, b_signed, sa, sb;
  logic [W-1:0]    abs_a, abs_b;
  logic [W:0]      mul_sum;
  logic [W:0]      rem_sh;
  logic            div_ge;
  logic [W-1:0]    rem_new;
  logic [2*W-1:0]  step_next;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quot_fix, rem_fix;
  logic [W-1:0]    res_sel;

  // Operand signedness and magnitudes for the request on the inputs
  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    sa       = a_signed && read_data_1[W-1];
    sb       = b_signed && read_data_2[W-1];
    abs_a    = sa ? W'(-read_data_1) : read_data_1;
    abs_b    = sb ? W'(-read_data_2) : read_data_2;
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (sh[0] ? {1'b0, opnd} : (W+1)'(0));
    rem_sh  = {acc[2*W-1:W], sh[W-1]};
    div_ge  = (rem_sh >= {1'b0, opnd});
    rem_new = div_ge ? W'(rem_sh - {1'b0, opnd}) : rem_sh[W-1:0];
    if (op_q[2]) step_next = {rem_new, acc[W-2:0], div_ge};
    else         step_next = {mul_sum, acc[W-1:1]};
  end

  // Sign correction, special cases and output selection
  always_comb begin
    prod_fix = neg_q ? (2*W)'(-acc) : acc;
    quot_fix = neg_q ? W'(-acc[W-1:0]) : acc[W-1:0];
    rem_fix  = neg_r ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
    case (op_q)
      3'b000:         res_sel = prod_fix[W-1:0];
      3'b001, 3'b010,
      3'b011:         res_sel = prod_fix[2*W-1:W];
      3'b100, 3'b101: res_sel = div0 ? {W{1'b1}} : quot_fix;
      default:        res_sel = rem_fix;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      acc    <= '0;
      op_q   <= '0;
      opnd   <= '0;
      sh     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q  <= op;
            opnd  <= op[2] ? abs_b : abs_a;
            sh    <= op[2] ? abs_a : abs_b;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            div0  <= (read_data_2 == '0);
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= step_next;
          sh  <= op_q[2] ? {sh[W-2:0], 1'b0} : {1'b0, sh[W-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          result <= res_sel;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: results, 34-cycle latency, ignored starts,
// back-to-back issue and mid-operation reset.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  md_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request; it is accepted on the next rising edge
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; read_data_1 = a; read_data_2 = b;
  endtask

  // Take the accepting edge, track busy for 33 cycles, then check done/result.
  // With noise set, extra starts with junk operands are pulsed at T+5 and T+20.
  task automatic finish(input string tag, input logic [31:0] exp, input bit noise,
                        input logic [31:0] hold);
    bit busy_ok = 1'b1;
    bit hold_ok = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 33; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
      if (result !== hold) hold_ok = 1'b0;
      if (noise && (k == 5 || k == 20)) begin
        start = 1'b1; op = 3'(k); read_data_1 = 32'(k * 77); read_data_2 = 32'h3;
      end else begin
        start = 1'b0; read_data_1 = 32'hDEAD_BEEF; read_data_2 = 32'h0000_0001;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
    if (noise) chk({tag, "_hold"}, {31'b0, hold_ok}, 32'd1);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_nbusy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_res"}, result, exp);
  endtask

  // One idle cycle after done: pulse must drop, result must hold
  task automatic idle_check(input string tag, input logic [31:0] exp);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, "_held"}, result, exp);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input logic [31:0] prev);
    launch(o, a, b);
    finish(tag, exp, 1'b0, prev);
    idle_check(tag, exp);
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; op = '0; read_data_1 = '0; read_data_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'h0);
    run("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'hFFFF_FFEB);
    run("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h4000_0000);
    run("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu",   3'b101, 32'd100,        32'd7,         32'd14,        32'hFFFF_FFFF);
    run("remu",   3'b111, 32'd100,        32'd7,         32'd2,         32'd14);
    run("div0",   3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 32'd2);
    run("rem0",   3'b110, 32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF);
    run("divn0",  3'b100, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 32'd5);
    run("divovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF);
    run("removf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000);

    // Starts while busy are ignored; then a start in the DONE cycle chains
    launch(3'b000, 32'd1000, 32'd1000);
    finish("noise", 32'd1_000_000, 1'b1, 32'd0);
    launch(3'b101, 32'd1000, 32'd9);
    finish("b2b", 32'd111, 1'b0, 32'd1_000_000);
    idle_check("b2b", 32'd111);

    // Reset at T+10 aborts the operation with no done pulse
    launch(3'b000, 32'd3, 32'd4);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_res", result, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_nodone", {31'b0, saw_done}, 32'd0);
    run("fresh", 3'b000, 32'd3, 32'd4, 32'd12, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit for the RV32M instructions, placed beside the single-cycle ALU in the execute stage. The decoder pulses `start` with a 3-bit `op`, and the pipeline stalls while `busy` is high. The unit captures both operands and runs a fixed-latency shift-add multiply or restoring divide. It returns a 32-bit `result` with a one-cycle `done` pulse, which the write-back mux selects in place of `Alu_result`.

## Interface
- Parameters: none. The datapath width is fixed at 32 bits.
- `clk` in 1: the single system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request pulse; sampled only when `busy`=0.
- `op` in 3: RISC-V funct3 encoding: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- `read_data_1` in 32: rs1 operand, captured on the accepting edge.
- `read_data_2` in 32: rs2 operand, captured on the accepting edge.
- `busy` out 1: high while an operation is in flight (CALC or FIX states).
- `done` out 1: one-cycle pulse; `result` is valid in the same cycle.
- `result` out 32: final value; held until the next accepted `start` or `rst`.

## Operation
- States: IDLE, CALC, FIX, DONE; 2-bit encoding.
- IDLE or DONE with `start`=1, on the edge:
  - Latch `op`.
  - Latch the absolute values of the operands per signedness (mulh: both signed; mulhsu: rs1 signed, rs2 unsigned; div/rem: both signed; others unsigned).
  - Latch the result sign flags.
  - Clear the 64-bit accumulator; set `cnt`=0; go to CALC.
- IDLE or DONE with `start`=0: go to / stay in IDLE.
- CALC, multiply: each cycle, if multiplier LSB=1 add the multiplicand to the upper accumulator half, then shift right by 1.
- CALC, divide: each cycle, shift {rem,quot} left by 1, trial-subtract the divisor, and set the quotient bit if non-negative (restoring).
- CALC transitions: `cnt` increments each cycle; after the iteration with `cnt`=31, go to FIX.
- FIX: apply sign correction (two's complement negate when the sign flag is set), select the output, write `result`, go to DONE.
- Output selection:
  - mul: low 32 bits of the product.
  - mulh, mulhsu, mulhu: high 32 bits.
  - div/divu: quotient; rem/remu: remainder.
  - Remainder sign follows the dividend.
- Special cases, resolved in FIX with the same fixed latency:
  - Divide by zero: div/divu quotient = 32'hFFFF_FFFF; rem/remu = rs1.
  - Signed overflow (rs1=32'h8000_0000, rs2=32'hFFFF_FFFF): div = 32'h8000_0000; rem = 0.
- DONE: `done`=1 for exactly this cycle. Next state is CALC if `start`=1 (back-to-back), else IDLE.
- `start` while `busy`=1 is ignored; no queuing and no error flag.
- `op` and operands are don't-care except on the accepting edge. Changes mid-operation have no effect.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, `cnt`=0, accumulator=0.
- `rst` in any state, including mid-CALC, aborts the operation on that edge with no `done` pulse. `result` is cleared.
- Accepting edge at cycle T:
  - `busy`=1 in cycles T+1 through T+33 (32 CALC cycles plus 1 FIX cycle).
  - `done`=1 and `result` valid in cycle T+34; `busy`=0 in that cycle.
- Latency: 34 cycles from `start` to `done` for every `op`, including the special cases.
- Maximum throughput is one operation per 34 cycles: a `start` in the DONE cycle is accepted, giving the next `done` 34 cycles later.
- `busy` and `done` are registered outputs; there is no combinational path from `start` to `busy`.
- `result` changes only on the FIX→DONE edge or on `rst`.

## Test plan
- Multiply: mul 7×(−3) → 32'hFFFF_FFEB; mulh 32'h8000_0000×32'h8000_0000 → 32'h4000_0000; mulhu 32'hFFFF_FFFF×32'hFFFF_FFFF → 32'hFFFF_FFFE; mulhsu 32'hFFFF_FFFF×2 → 32'hFFFF_FFFF. Each `done` lands exactly 34 cycles after `start`.
- Divide: div −7/2 → 32'hFFFF_FFFD; rem −7/2 → 32'hFFFF_FFFF; divu 100/7 → 14; remu 100/7 → 2.
- Special cases: div 5/0 → 32'hFFFF_FFFF; rem 5/0 → 5; div 32'h8000_0000/−1 → 32'h8000_0000; rem of the same → 0. All at 34-cycle latency.
- Handshake: pulse `start` at cycles T+5 and T+20 of an operation, changing the operands each time → both ignored and `result` unaffected. A `start` in the DONE cycle starts a second operation, whose `done` arrives 34 cycles later.
- Reset mid-operation: `rst` at cycle T+10 → next cycle `busy`=0, `done`=0, `result`=0; no `done` pulse for the aborted op; a fresh `start` then completes normally.
- Random regression: 10k random op/operand pairs compared against a behavioral RV32M model; check `done` width is exactly 1 cycle and that `result` holds steady between `done` pulses.
